axi_lite_cfg_slave: RTL and testbench

AXI4-Lite responder at the CPU-facing edge of zyNet. It terminates the control-plane write and read channels and converts register writes into weight and bias load strobes with layer and neuron select. It captures the classification result from the network, raises the result interrupt, and drives the network soft reset.

---
 rtl/axi_lite_cfg_slave.sv | 188 ++++++++++++++++++
 tb/tb_axi_lite_cfg_slave.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cfg_slave.sv
// AXI4-Lite configuration responder for the zyNet control plane.
// Turns register writes into weight/bias load strobes and layer/neuron selects,
// captures the network's classification result, raises a level interrupt and
// owns the network soft reset.
//
// Ports:
//   s_axi_aclk / s_axi_aresetn     clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  write address, data and response channels
//   s_axi_ar* / s_axi_r*           read address and data channels
//   weight_value / weight_valid    last weight written, one-cycle load strobe
//   bias_value / bias_valid        last bias written, one-cycle load strobe
//   layer_number / neuron_number   layer and neuron select registers
//   soft_reset                     active-high network reset (set out of reset)
//   result_value / result_valid    classification result from the network
//   intr                           level interrupt, result pending
module axi_lite_cfg_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned dataWidth          = 16
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [dataWidth-1:0]            weight_value,
    output logic                            weight_valid,
    output logic [dataWidth-1:0]            bias_value,
    output logic                            bias_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   layer_number,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   neuron_number,
    output logic                            soft_reset,
    input  logic [dataWidth-1:0]            result_value,
    input  logic                            result_valid,
    output logic                            intr
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    // Word index = addr[4:2]
    localparam logic [2:0] REG_WEIGHT   = 3'd0;
    localparam logic [2:0] REG_BIAS     = 3'd1;
    localparam logic [2:0] REG_RESULT   = 3'd2;
    localparam logic [2:0] REG_LAYER    = 3'd3;
    localparam logic [2:0] REG_NEURON   = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;
    localparam logic [2:0] REG_SOFT_RST = 3'd7;

    logic [dataWidth-1:0] result_reg;
    logic                 wr_en_c;
    logic                 rd_en_c;
    logic [2:0]           wr_idx_c;
    logic [2:0]           rd_idx_c;
    logic                 capture_c;
    logic                 soft_clear_c;
    logic                 result_rd_c;
    logic [DW-1:0]        rd_mux_c;
    logic                 unused_c;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    // Protection and byte-offset address bits carry no meaning here
    assign unused_c = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Handshake cycles: ready pulses only while both sides still present valid
    assign wr_en_c      = s_axi_awready && s_axi_awvalid && s_axi_wready && s_axi_wvalid;
    assign rd_en_c      = s_axi_arready && s_axi_arvalid;
    assign wr_idx_c     = s_axi_awaddr[4:2];
    assign rd_idx_c     = s_axi_araddr[4:2];
    assign capture_c    = result_valid && !soft_reset;
    assign soft_clear_c = wr_en_c && (wr_idx_c == REG_SOFT_RST) && s_axi_wdata[0];
    assign result_rd_c  = rd_en_c && (rd_idx_c == REG_RESULT);

    // Byte-strobed merge of write data into an existing register value
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] cur,
                                                 input logic [DW-1:0] wd,
                                                 input logic [STRB_W-1:0] st);
        logic [DW-1:0] r;
        r = cur;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Read data selection, sampled into rdata on the read accept cycle
    always_comb begin
        rd_mux_c = '0;
        case (rd_idx_c)
            REG_RESULT:   rd_mux_c = DW'(result_reg);
            REG_LAYER:    rd_mux_c = layer_number;
            REG_NEURON:   rd_mux_c = neuron_number;
            REG_STATUS:   rd_mux_c = DW'({soft_reset, intr});
            REG_SOFT_RST: rd_mux_c = DW'(soft_reset);
            default:      rd_mux_c = '0;
        endcase
    end

    // Write channel and write-side registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            weight_value  <= '0;
            weight_valid  <= 1'b0;
            bias_value    <= '0;
            bias_valid    <= 1'b0;
            layer_number  <= '0;
            neuron_number <= '0;
        end else begin
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            weight_valid  <= 1'b0;
            bias_valid    <= 1'b0;
            if (wr_en_c) begin
                s_axi_bvalid <= 1'b1;
                case (wr_idx_c)
                    REG_WEIGHT: begin
                        weight_value <= s_axi_wdata[dataWidth-1:0];
                        weight_valid <= 1'b1;
                    end
                    REG_BIAS: begin
                        bias_value <= s_axi_wdata[dataWidth-1:0];
                        bias_valid <= 1'b1;
                    end
                    REG_LAYER:  layer_number  <= apply_strb(layer_number, s_axi_wdata, s_axi_wstrb);
                    REG_NEURON: neuron_number <= apply_strb(neuron_number, s_axi_wdata, s_axi_wstrb);
                    default: ;
                endcase
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // Result capture, interrupt and soft reset; soft-reset clear beats capture,
    // capture beats the clear-on-read of RESULT
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            result_reg <= '0;
            intr       <= 1'b0;
            soft_reset <= 1'b1;
        end else begin
            if (capture_c) result_reg <= result_value;
            if (soft_clear_c)     intr <= 1'b0;
            else if (capture_c)   intr <= 1'b1;
            else if (result_rd_c) intr <= 1'b0;
            if (wr_en_c && (wr_idx_c == REG_SOFT_RST)) soft_reset <= s_axi_wdata[0];
        end
    end

    // Read channel
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_en_c) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux_c;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
// Self-checking bench for axi_lite_cfg_slave: directed scenarios plus a
// randomized sequence, all checked against a register-level reference model.
module tb_axi_lite_cfg_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [15:0] weight_value;
    logic        weight_valid;
    logic [15:0] bias_value;
    logic        bias_valid;
    logic [31:0] layer_number;
    logic [31:0] neuron_number;
    logic        soft_reset;
    logic [15:0] result_value;
    logic        result_valid;
    logic        intr;

    always #5 clk = ~clk;

    axi_lite_cfg_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .weight_value  (weight_value),
        .weight_valid  (weight_valid),
        .bias_value    (bias_value),
        .bias_valid    (bias_valid),
        .layer_number  (layer_number),
        .neuron_number (neuron_number),
        .soft_reset    (soft_reset),
        .result_value  (result_value),
        .result_valid  (result_valid),
        .intr          (intr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural register state
    logic [31:0] m_layer, m_neuron;
    logic [15:0] m_weight, m_bias, m_result;
    logic        m_intr, m_soft;
    int          exp_wpulse = 0, exp_bpulse = 0;
    int          got_wpulse = 0, got_bpulse = 0;

    always @(negedge clk) begin
        if (weight_valid) got_wpulse++;
        if (bias_valid)   got_bpulse++;
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd2:    return {16'h0, m_result};
            3'd3:    return m_layer;
            3'd4:    return m_neuron;
            3'd5:    return {30'h0, m_soft, m_intr};
            3'd7:    return {31'h0, m_soft};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        m_layer = '0; m_neuron = '0; m_weight = '0; m_bias = '0;
        m_result = '0; m_intr = 1'b0; m_soft = 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Full write transaction; optional result pulse lands on the accept cycle
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, input bit pulse, input logic [15:0] pv);
        int k;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!awready && k < 20) begin @(negedge clk); k++; end
        n_vec++;
        if (!awready || !wready) begin
            n_err++;
            $display("FAIL aw_accept: awready %b wready %b expected 1 1", awready, wready);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (pulse) begin result_valid = 1'b1; result_value = pv; end
        if (pulse && !m_soft) begin m_result = pv; m_intr = 1'b1; end
        case (a[4:2])
            3'd0: begin m_weight = d[15:0]; exp_wpulse++; end
            3'd1: begin m_bias = d[15:0]; exp_bpulse++; end
            3'd3: for (int b = 0; b < 4; b++) if (s[b]) m_layer[8*b +: 8] = d[8*b +: 8];
            3'd4: for (int b = 0; b < 4; b++) if (s[b]) m_neuron[8*b +: 8] = d[8*b +: 8];
            3'd7: begin m_soft = d[0]; if (d[0]) m_intr = 1'b0; end
            default: ;
        endcase
        @(negedge clk);
        result_valid = 1'b0;
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'd0);
        chk("weight_valid", 32'(weight_valid), 32'(a[4:2] == 3'd0));
        chk("bias_valid", 32'(bias_valid), 32'(a[4:2] == 3'd1));
        chk("weight_value", 32'(weight_value), 32'(m_weight));
        chk("bias_value", 32'(bias_value), 32'(m_bias));
        chk("layer_number", layer_number, m_layer);
        chk("neuron_number", neuron_number, m_neuron);
        chk("soft_reset", 32'(soft_reset), 32'(m_soft));
        chk("intr_after_wr", 32'(intr), 32'(m_intr));
        for (int h = 0; h < hold; h++) begin
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("no_reaccept", 32'(awready), 32'd0);
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        chk("bvalid_clear", 32'(bvalid), 32'd0);
        bready = 1'b0;
    endtask

    // Full read transaction; optional result pulse lands on the accept cycle
    task automatic axi_read(input logic [4:0] a, input bit pulse, input logic [15:0] pv);
        int k;
        logic [31:0] exp;
        araddr = a; arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!arready && k < 20) begin @(negedge clk); k++; end
        n_vec++;
        if (!arready) begin
            n_err++;
            $display("FAIL ar_accept: arready %b expected 1", arready);
            arvalid = 1'b0;
            return;
        end
        exp = model_read(a);
        if (a[4:2] == 3'd2) m_intr = 1'b0;
        if (pulse) begin result_valid = 1'b1; result_value = pv; end
        if (pulse && !m_soft) begin m_result = pv; m_intr = 1'b1; end
        @(negedge clk);
        arvalid = 1'b0; result_valid = 1'b0;
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rdata", rdata, exp);
        chk("rresp", 32'(rresp), 32'd0);
        chk("intr_after_rd", 32'(intr), 32'(m_intr));
        rready = 1'b1;
        @(negedge clk);
        chk("rvalid_clear", 32'(rvalid), 32'd0);
        rready = 1'b0;
    endtask

    task automatic pulse_result(input logic [15:0] v);
        result_valid = 1'b1; result_value = v;
        @(negedge clk);
        result_valid = 1'b0;
        if (!m_soft) begin m_result = v; m_intr = 1'b1; end
        chk("intr_after_result", 32'(intr), 32'(m_intr));
    endtask

    task automatic check_pulses(input string tag);
        @(negedge clk); #1;
        chk({tag, "_wpulses"}, 32'(got_wpulse), 32'(exp_wpulse));
        chk({tag, "_bpulses"}, 32'(got_bpulse), 32'(exp_bpulse));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        result_value = '0; result_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_soft_reset", 32'(soft_reset), 32'd1);
        chk("rst_intr", 32'(intr), 32'd0);
        chk("rst_valids", 32'({awready, wready, bvalid, arready, rvalid, weight_valid, bias_valid}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_layer", layer_number, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_soft_reset", 32'(soft_reset), 32'd1);
    endtask

    task automatic test_soft_release();
        axi_write(5'h1C, 32'h0, 4'hF, 0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        axi_write(5'h0C, 32'd2, 4'hF, 0, 1'b0, 16'h0);
        axi_write(5'h10, 32'd5, 4'hF, 0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) axi_write(5'h00, 32'h0000ABCD, 4'hF, 0, 1'b0, 16'h0);
        check_pulses("b2b");
    endtask

    task automatic test_bias_hold();
        axi_write(5'h04, 32'h1234, 4'hF, 4, 1'b0, 16'h0);
        check_pulses("bias_hold");
    endtask

    task automatic test_result_intr();
        pulse_result(16'd7);
        axi_read(5'h14, 1'b0, 16'h0);
        axi_read(5'h08, 1'b0, 16'h0);
        axi_read(5'h14, 1'b0, 16'h0);
    endtask

    task automatic test_simultaneous();
        axi_read(5'h08, 1'b1, 16'd3);
        axi_read(5'h08, 1'b0, 16'h0);
        // Capture and SOFT_RST=1 write in the same cycle: clear wins
        pulse_result(16'd9);
        axi_write(5'h1C, 32'h1, 4'hF, 0, 1'b1, 16'd4);
        axi_read(5'h14, 1'b0, 16'h0);
        pulse_result(16'd5);
        axi_write(5'h1C, 32'h0, 4'hF, 0, 1'b0, 16'h0);
        axi_read(5'h08, 1'b0, 16'h0);
    endtask

    task automatic test_strobe_and_reset();
        int k;
        axi_write(5'h0C, 32'h0, 4'hF, 0, 1'b0, 16'h0);
        axi_write(5'h0C, 32'h11223344, 4'b0011, 0, 1'b0, 16'h0);
        chk("strobe_layer", layer_number, 32'h00003344);
        axi_read(5'h18, 1'b0, 16'h0);
        axi_read(5'h00, 1'b0, 16'h0);
        araddr = 5'h0C; arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!arready && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        arvalid = 1'b0;
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_soft_reset", 32'(soft_reset), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_layer", layer_number, 32'd0);
        axi_write(5'h1C, 32'h0, 4'hF, 0, 1'b0, 16'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [4:0] a;
            a = {3'($urandom_range(0, 7)), 2'b00};
            case ($urandom_range(0, 3))
                0: begin
                    logic [31:0] d;
                    d = $urandom;
                    // keep the network mostly out of reset so captures matter
                    if (a == 5'h1C && $urandom_range(0, 3) != 0) d[0] = 1'b0;
                    axi_write(a, d, 4'($urandom), 0, 1'($urandom_range(0, 1)), 16'($urandom));
                end
                1: axi_read(a, 1'b0, 16'h0);
                2: pulse_result(16'($urandom));
                default: axi_read(a, 1'b1, 16'($urandom));
            endcase
        end
        check_pulses("random");
    endtask

    initial begin
        test_reset();
        test_soft_release();
        test_back_to_back();
        test_bias_hold();
        test_result_intr();
        test_simultaneous();
        test_strobe_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
